// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath: sequences fetch, decode,
// execute, memory, write-back, multiply/divide wait and exception entry.
module control_unit #(
  parameter int MD_CYCLES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  input  logic [5:0] funct,
  input  logic       eqf,
  input  logic       gtf,
  input  logic       ov,
  input  logic       div0,
  output logic       MemCtrl,
  output logic       PCCtrl,
  output logic       MDCtrl,
  output logic       SECtrl,
  output logic       ShiftSrc,
  output logic       ShiftAmt,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUOutCtrl,
  output logic       EPCCtrl,
  output logic       HILOWrite,
  output logic [1:0] IorD,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] RegDst,
  output logic [1:0] LSCtrl,
  output logic [1:0] SSCtrl,
  output logic [1:0] ExcptCtrl,
  output logic [2:0] ShiftCtrl,
  output logic [2:0] PCSrc,
  output logic [2:0] ALUCtrl,
  output logic [3:0] DataSrc
);

  localparam logic [5:0] MD_LAST = 6'(MD_CYCLES - 1);
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_CMP  = 3'b111;

  typedef enum logic [4:0] {
    stReset, stFetch, stFWait, stIrLd, stDecode, stArith, stAddi, stWbAlu,
    stSlt, stBranch, stAddr, stMRd, stMWait, stWbLd, stSwRd, stSwWait,
    stSw, stMdWait, stMdDone, stMfWb, stShift, stShiftOp, stShiftWb, stLui,
    stJr, stJump, stJal, stWbRa, stExc, stExcRd, stExcWait, stExcPc
  } stateT;

  stateT       state, nextState;
  logic [5:0]  mdCount;
  logic [1:0]  excCode, excNext;
  logic        isDiv;
  logic        unusedGtf;

  assign isDiv     = (funct == 6'h1A);
  assign unusedGtf = gtf;

  // The MD counter only runs while waiting, so it is zero on every entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= stReset;
      mdCount <= 6'd0;
      excCode <= 2'd0;
    end else begin
      state   <= nextState;
      excCode <= excNext;
      mdCount <= (state == stMdWait) ? mdCount + 6'd1 : 6'd0;
    end
  end

  always_comb begin
    nextState  = state;
    excNext    = excCode;
    MemCtrl    = 1'b0;
    PCCtrl     = 1'b0;
    MDCtrl     = 1'b0;
    SECtrl     = 1'b0;
    ShiftSrc   = 1'b0;
    ShiftAmt   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUOutCtrl = 1'b0;
    EPCCtrl    = 1'b0;
    HILOWrite  = 1'b0;
    IorD       = 2'd0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    RegDst     = 2'd0;
    LSCtrl     = 2'd0;
    SSCtrl     = 2'd0;
    ExcptCtrl  = 2'd0;
    ShiftCtrl  = 3'b000;
    PCSrc      = 3'd0;
    ALUCtrl    = ALU_PASS;
    DataSrc    = 4'd0;

    case (state)
      stReset:  nextState = stFetch;
      stFetch: begin
        ALUSrcB   = 2'd1;
        ALUCtrl   = ALU_ADD;
        PCCtrl    = 1'b1;
        nextState = stFWait;
      end
      stFWait:  nextState = stIrLd;
      stIrLd: begin
        IRWrite   = 1'b1;
        nextState = stDecode;
      end
      // Branch target is precomputed here while the opcode is dispatched.
      stDecode: begin
        ALUSrcB    = 2'd3;
        ALUCtrl    = ALU_ADD;
        ALUOutCtrl = 1'b1;
        nextState  = stExc;
        excNext    = 2'd0;
        if (opCode == 6'h00) begin
          case (funct)
            6'h20, 6'h22, 6'h24: nextState = stArith;
            6'h2A:               nextState = stSlt;
            6'h18, 6'h1A:        nextState = stMdWait;
            6'h10, 6'h12:        nextState = stMfWb;
            6'h08:               nextState = stJr;
            6'h00, 6'h02:        nextState = stShift;
            default:             nextState = stExc;
          endcase
        end else begin
          case (opCode)
            6'h08:        nextState = stAddi;
            6'h04, 6'h05: nextState = stBranch;
            6'h23, 6'h2B: nextState = stAddr;
            6'h0F:        nextState = stLui;
            6'h02:        nextState = stJump;
            6'h03:        nextState = stJal;
            default:      nextState = stExc;
          endcase
        end
      end
      stArith, stAddi: begin
        ALUSrcA    = 2'd1;
        ALUOutCtrl = 1'b1;
        if (state == stAddi) begin
          ALUSrcB = 2'd2;
          ALUCtrl = ALU_ADD;
        end else begin
          case (funct)
            6'h22:   ALUCtrl = ALU_SUB;
            6'h24:   ALUCtrl = ALU_AND;
            default: ALUCtrl = ALU_ADD;
          endcase
        end
        if (ov) begin
          nextState = stExc;
          excNext   = 2'd1;
        end else begin
          nextState = stWbAlu;
        end
      end
      stWbAlu: begin
        RegDst    = (opCode == 6'h00) ? 2'd1 : 2'd0;
        RegWrite  = 1'b1;
        nextState = stFetch;
      end
      stSlt: begin
        ALUSrcA   = 2'd1;
        ALUCtrl   = ALU_CMP;
        RegDst    = 2'd1;
        DataSrc   = 4'd4;
        RegWrite  = 1'b1;
        nextState = stFetch;
      end
      stBranch: begin
        ALUSrcA   = 2'd1;
        ALUCtrl   = ALU_CMP;
        PCSrc     = 3'd1;
        PCCtrl    = (opCode == 6'h04) ? eqf : ~eqf;
        nextState = stFetch;
      end
      stAddr: begin
        ALUSrcA    = 2'd1;
        ALUSrcB    = 2'd2;
        ALUCtrl    = ALU_ADD;
        ALUOutCtrl = 1'b1;
        nextState  = (opCode == 6'h2B) ? stSwRd : stMRd;
      end
      stMRd: begin
        IorD      = 2'd2;
        nextState = stMWait;
      end
      stMWait: begin
        IorD      = 2'd2;
        nextState = stWbLd;
      end
      stWbLd: begin
        IorD      = 2'd2;
        DataSrc   = 4'd1;
        RegWrite  = 1'b1;
        nextState = stFetch;
      end
      stSwRd: begin
        IorD      = 2'd2;
        nextState = stSwWait;
      end
      stSwWait: begin
        IorD      = 2'd2;
        nextState = stSw;
      end
      stSw: begin
        IorD      = 2'd2;
        MemCtrl   = 1'b1;
        nextState = stFetch;
      end
      // Divide-by-zero aborts a divide on whichever wait cycle it appears.
      stMdWait: begin
        MDCtrl = isDiv && (mdCount == 6'd0);
        if (isDiv && div0) begin
          nextState = stExc;
          excNext   = 2'd2;
        end else if (mdCount == MD_LAST) begin
          nextState = stMdDone;
        end
      end
      stMdDone: begin
        HILOWrite = 1'b1;
        nextState = stFetch;
      end
      stMfWb: begin
        DataSrc   = (funct == 6'h10) ? 4'd2 : 4'd3;
        RegDst    = 2'd1;
        RegWrite  = 1'b1;
        nextState = stFetch;
      end
      stShift: begin
        ShiftSrc  = 1'b1;
        ShiftAmt  = 1'b1;
        ShiftCtrl = 3'b001;
        nextState = stShiftOp;
      end
      stShiftOp: begin
        ShiftCtrl = (funct == 6'h00) ? 3'b010 : 3'b011;
        nextState = stShiftWb;
      end
      stShiftWb: begin
        DataSrc   = 4'd8;
        RegDst    = 2'd1;
        RegWrite  = 1'b1;
        nextState = stFetch;
      end
      stLui: begin
        DataSrc   = 4'd6;
        RegWrite  = 1'b1;
        nextState = stFetch;
      end
      stJr: begin
        ALUSrcA   = 2'd1;
        PCCtrl    = 1'b1;
        nextState = stFetch;
      end
      stJump: begin
        PCSrc     = 3'd2;
        PCCtrl    = 1'b1;
        nextState = stFetch;
      end
      stJal: begin
        ALUOutCtrl = 1'b1;
        nextState  = stWbRa;
      end
      stWbRa: begin
        RegDst    = 2'd3;
        RegWrite  = 1'b1;
        nextState = stJump;
      end
      stExc: begin
        ALUSrcB   = 2'd1;
        ALUCtrl   = ALU_SUB;
        EPCCtrl   = 1'b1;
        nextState = stExcRd;
      end
      stExcRd, stExcWait: begin
        IorD      = 2'd3;
        ExcptCtrl = excCode;
        nextState = (state == stExcRd) ? stExcWait : stExcPc;
      end
      stExcPc: begin
        LSCtrl    = 2'd2;
        PCSrc     = 3'd3;
        PCCtrl    = 1'b1;
        nextState = stFetch;
      end
      default: nextState = stReset;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: an instruction-level model pushes the
// expected per-cycle control vectors, a negedge monitor pops and compares.
module tb_control_unit;

  localparam int MD = 32;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode, funct;
  logic       eqf, gtf, ov, div0;
  logic       MemCtrl, PCCtrl, MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IRWrite;
  logic       RegWrite, ALUOutCtrl, EPCCtrl, HILOWrite;
  logic [1:0] IorD, ALUSrcA, ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl;
  logic [2:0] ShiftCtrl, PCSrc, ALUCtrl;
  logic [3:0] DataSrc;

  typedef struct packed {
    logic       memCtrl, pcCtrl, mdCtrl, seCtrl, shiftSrc, shiftAmt, irWrite;
    logic       regWrite, aluOutCtrl, epcCtrl, hiloWrite;
    logic [1:0] iorD, aluSrcA, aluSrcB, regDst, lsCtrl, ssCtrl, excptCtrl;
    logic [2:0] shiftCtrl, pcSrc, aluCtrl;
    logic [3:0] dataSrc;
  } ctlT;

  typedef enum {iAdd, iSub, iAnd, iSlt, iMult, iDiv, iMfhi, iMflo, iJr, iSll,
                iSrl, iAddi, iBeq, iBne, iLw, iSw, iLui, iJ, iJal, iBad} instrT;

  logic [5:0] tblOp[19]   = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h04, 6'h05,
                              6'h23, 6'h2B, 6'h0F, 6'h02, 6'h03};
  logic [5:0] tblFn[19]   = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h18, 6'h1A, 6'h10,
                              6'h12, 6'h08, 6'h00, 6'h02, 6'h00, 6'h00, 6'h00,
                              6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
  instrT      tblKind[19] = '{iAdd, iSub, iAnd, iSlt, iMult, iDiv, iMfhi, iMflo,
                              iJr, iSll, iSrl, iAddi, iBeq, iBne, iLw, iSw,
                              iLui, iJ, iJal};

  ctlT   act;
  ctlT   expQ[$];
  string tagQ[$];
  ctlT   seqQ[$];
  string seqTag[$];
  int    errors = 0;
  int    checks = 0;

  control_unit #(.MD_CYCLES(MD)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct), .eqf(eqf),
    .gtf(gtf), .ov(ov), .div0(div0), .MemCtrl(MemCtrl), .PCCtrl(PCCtrl),
    .MDCtrl(MDCtrl), .SECtrl(SECtrl), .ShiftSrc(ShiftSrc), .ShiftAmt(ShiftAmt),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUOutCtrl(ALUOutCtrl),
    .EPCCtrl(EPCCtrl), .HILOWrite(HILOWrite), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .RegDst(RegDst), .LSCtrl(LSCtrl), .SSCtrl(SSCtrl),
    .ExcptCtrl(ExcptCtrl), .ShiftCtrl(ShiftCtrl), .PCSrc(PCSrc),
    .ALUCtrl(ALUCtrl), .DataSrc(DataSrc)
  );

  assign act = {MemCtrl, PCCtrl, MDCtrl, SECtrl, ShiftSrc, ShiftAmt, IRWrite,
                RegWrite, ALUOutCtrl, EPCCtrl, HILOWrite, IorD, ALUSrcA,
                ALUSrcB, RegDst, LSCtrl, SSCtrl, ExcptCtrl, ShiftCtrl, PCSrc,
                ALUCtrl, DataSrc};

  always #5 clk = ~clk;

  // Monitor: every falling edge consumes one expected control vector.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      ctlT   e;
      string t;
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("[TB] FAIL %s: got %h, required %h", t, act, e);
      end
    end
  end

  function automatic instrT classify(logic [5:0] op, logic [5:0] fn);
    for (int i = 0; i < 19; i++)
      if (tblOp[i] == op && (op != 6'h00 || tblFn[i] == fn)) return tblKind[i];
    return iBad;
  endfunction

  function automatic void add(ctlT v, string t);
    seqQ.push_back(v);
    seqTag.push_back(t);
  endfunction

  function automatic void addExc(logic [1:0] code);
    ctlT v;
    v = '0; v.aluSrcB = 2'd1; v.aluCtrl = 3'b010; v.epcCtrl = 1'b1; add(v, "exc");
    v = '0; v.iorD = 2'd3; v.excptCtrl = code; add(v, "excRd"); add(v, "excWait");
    v = '0; v.lsCtrl = 2'd2; v.pcSrc = 3'd3; v.pcCtrl = 1'b1; add(v, "excPc");
  endfunction

  // Reference model: the full cycle-by-cycle control trace of one instruction.
  function automatic void buildSeq(logic [5:0] op, logic [5:0] fn, logic eq,
                                   logic ovf, int divZeroAt);
    ctlT   v;
    instrT k;
    seqQ.delete();
    seqTag.delete();
    v = '0; v.aluSrcB = 2'd1; v.aluCtrl = 3'b001; v.pcCtrl = 1'b1; add(v, "fetch");
    v = '0; add(v, "fwait");
    v.irWrite = 1'b1; add(v, "irld");
    v = '0; v.aluSrcB = 2'd3; v.aluCtrl = 3'b001; v.aluOutCtrl = 1'b1; add(v, "decode");
    k = classify(op, fn);
    v = '0;
    case (k)
      iAdd, iSub, iAnd, iAddi: begin
        v.aluSrcA = 2'd1;
        v.aluSrcB = (k == iAddi) ? 2'd2 : 2'd0;
        v.aluCtrl = (k == iSub) ? 3'b010 : (k == iAnd) ? 3'b011 : 3'b001;
        v.aluOutCtrl = 1'b1;
        add(v, "exec");
        if (ovf) addExc(2'd1);
        else begin
          v = '0; v.regDst = (k == iAddi) ? 2'd0 : 2'd1; v.regWrite = 1'b1;
          add(v, "wb");
        end
      end
      iSlt: begin
        v.aluSrcA = 2'd1; v.aluCtrl = 3'b111; v.regDst = 2'd1;
        v.dataSrc = 4'd4; v.regWrite = 1'b1; add(v, "slt");
      end
      iBeq, iBne: begin
        v.aluSrcA = 2'd1; v.aluCtrl = 3'b111; v.pcSrc = 3'd1;
        v.pcCtrl = (k == iBeq) ? eq : !eq; add(v, "branch");
      end
      iLw, iSw: begin
        v.aluSrcA = 2'd1; v.aluSrcB = 2'd2; v.aluCtrl = 3'b001;
        v.aluOutCtrl = 1'b1; add(v, "addr");
        v = '0; v.iorD = 2'd2; add(v, "mem1"); add(v, "mem2");
        if (k == iLw) begin v.dataSrc = 4'd1; v.regWrite = 1'b1; end
        else v.memCtrl = 1'b1;
        add(v, "memEnd");
      end
      iMult, iDiv: begin
        for (int c = 0; c < MD; c++) begin
          v = '0; v.mdCtrl = (c == 0 && k == iDiv); add(v, "mdWait");
          if (k == iDiv && c == divZeroAt) begin
            addExc(2'd2);
            return;
          end
        end
        v = '0; v.hiloWrite = 1'b1; add(v, "hilo");
      end
      iMfhi, iMflo: begin
        v.dataSrc = (k == iMfhi) ? 4'd2 : 4'd3; v.regDst = 2'd1;
        v.regWrite = 1'b1; add(v, "mfwb");
      end
      iSll, iSrl: begin
        v.shiftSrc = 1'b1; v.shiftAmt = 1'b1; v.shiftCtrl = 3'b001; add(v, "shLoad");
        v = '0; v.shiftCtrl = (k == iSll) ? 3'b010 : 3'b011; add(v, "shOp");
        v = '0; v.dataSrc = 4'd8; v.regDst = 2'd1; v.regWrite = 1'b1; add(v, "shWb");
      end
      iLui: begin v.dataSrc = 4'd6; v.regWrite = 1'b1; add(v, "lui"); end
      iJr:  begin v.aluSrcA = 2'd1; v.pcCtrl = 1'b1; add(v, "jr"); end
      iJ:   begin v.pcSrc = 3'd2; v.pcCtrl = 1'b1; add(v, "jump"); end
      iJal: begin
        v.aluOutCtrl = 1'b1; add(v, "jal");
        v = '0; v.regDst = 2'd3; v.regWrite = 1'b1; add(v, "wbRa");
        v = '0; v.pcSrc = 3'd2; v.pcCtrl = 1'b1; add(v, "jump");
      end
      default: addExc(2'd0);
    endcase
  endfunction

  task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                               input logic eq, input logic ovf,
                               input int divZeroAt, input int stopAfter);
    int    n;
    string name;
    opCode = op; funct = fn; eqf = eq; ov = ovf; gtf = 1'($urandom);
    buildSeq(op, fn, eq, ovf, divZeroAt);
    name = classify(op, fn).name();
    n = seqQ.size();
    if (stopAfter >= 0 && stopAfter < n) n = stopAfter;
    for (int i = 0; i < n; i++) begin
      expQ.push_back(seqQ[i]);
      tagQ.push_back($sformatf("%s.%s.c%0d", name, seqTag[i], i));
    end
    for (int i = 0; i < n; i++) begin
      div0 = (divZeroAt >= 0 && i == divZeroAt + 4);
      @(posedge clk); #1;
    end
    div0 = 1'b0;
  endtask

  task automatic doReset(input int holdCycles);
    reset = 1'b1;
    for (int h = 0; h < holdCycles; h++) begin
      expQ.push_back('0); tagQ.push_back($sformatf("reset.c%0d", h));
      @(posedge clk); #1;
    end
    reset = 1'b0;
    expQ.push_back('0); tagQ.push_back("resetRelease");
    @(posedge clk); #1;
  endtask

  task automatic checkOutput();
    @(negedge clk);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending vectors, required 0", expQ.size());
    end
  endtask

  initial begin
    reset = 1'b1; opCode = '0; funct = '0; eqf = 0; gtf = 0; ov = 0; div0 = 0;
    @(posedge clk); #1;
    doReset(3);
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h00, 6'h20, 1'b0, 1'b1, -1, -1);
    applyStimulus(6'h04, 6'h00, 1'b1, 1'b0, -1, -1);
    applyStimulus(6'h04, 6'h00, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h05, 6'h00, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h23, 6'h00, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h00, 6'h1A, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h00, 6'h1A, 1'b0, 1'b0, 4, -1);
    applyStimulus(6'h00, 6'h18, 1'b0, 1'b0, 4, -1);
    applyStimulus(6'h3F, 6'h00, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h00, 6'h3F, 1'b0, 1'b1, -1, -1);
    applyStimulus(6'h08, 6'h11, 1'b0, 1'b1, 3, -1);
    applyStimulus(6'h00, 6'h22, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h00, 6'h24, 1'b0, 1'b0, -1, -1);
    applyStimulus(6'h00, 6'h1A, 1'b0, 1'b0, -1, 10);
    doReset(1);
    applyStimulus(6'h2B, 6'h00, 1'b0, 1'b0, -1, 7);
    doReset(1);
    for (int i = 0; i < 19; i++)
      applyStimulus(tblOp[i], (tblOp[i] == 6'h00) ? tblFn[i] : 6'($urandom),
                    1'($urandom), 1'b0, -1, -1);
    for (int r = 0; r < 60; r++) begin
      logic [5:0] op, fn;
      int         idx;
      logic       ovf;
      idx = $urandom_range(0, 21);
      if (idx >= 19) begin
        op = 6'($urandom); fn = 6'($urandom);
      end else begin
        op = tblOp[idx];
        fn = (op == 6'h00) ? tblFn[idx] : 6'($urandom);
      end
      ovf = (classify(op, fn) == iAnd) ? 1'b0 : 1'($urandom);
      applyStimulus(op, fn, 1'($urandom), ovf,
                    ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 40)), -1);
    end
    checkOutput();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
